// File: rtl/mem_port_arbiter.sv
// Arbitrates the ifu fetch bus and the mem-unit data bus onto one shared memory port, with one transaction in flight.
// Optional feature: define RR_ARB_EN for round-robin ties; otherwise dbus has priority with a starvation guard.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  input  logic [63:0] i_addr,
  output logic        i_addr_ok,
  output logic        i_data_ok,
  output logic [31:0] i_data,
  input  logic        d_valid,
  input  logic [63:0] d_addr,
  input  logic [2:0]  d_size,
  input  logic [7:0]  d_strobe,
  input  logic [63:0] d_wdata,
  output logic        d_addr_ok,
  output logic        d_data_ok,
  output logic [63:0] d_rdata,
  output logic        m_valid,
  output logic [63:0] m_addr,
  output logic [2:0]  m_size,
  output logic [7:0]  m_strobe,
  output logic [63:0] m_wdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic [63:0] m_rdata,
  output logic        owner_d
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [63:0] addr_q_r;
  logic [63:0] wdata_q_r;
  logic [2:0]  size_q_r;
  logic [7:0]  strobe_q_r;
  logic        owner_d_r;
  logic        i_pend_r;
  logic        d_pend_r;
  logic        i_req_s;
  logic        d_req_s;
  logic        grant_s;
  logic        win_d_s;
  logic        resp_s;

  // A side with an outstanding transaction cannot be granted again.
  assign i_req_s = i_valid & ~i_pend_r;
  assign d_req_s = d_valid & ~d_pend_r;
  assign grant_s = (state_r == ST_IDLE) & (i_req_s | d_req_s) & ~rst;
  assign resp_s  = ((state_r == ST_REQ) & m_addr_ok & m_data_ok) |
                   ((state_r == ST_RESP) & m_data_ok);

`ifdef RR_ARB_EN
  assign win_d_s = d_req_s & (~i_req_s | ~owner_d_r);
`else
  localparam logic [3:0] STARVE_LIM_C = 4'(STARVE_LIMIT);
  logic [3:0] starve_cnt_r;

  assign win_d_s = d_req_s & (~i_req_s | (starve_cnt_r != STARVE_LIM_C));

  // Counts dbus wins taken while ibus is waiting; any ibus grant clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_r <= 4'd0;
    end else if (grant_s) begin
      if (!win_d_s) begin
        starve_cnt_r <= 4'd0;
      end else if (i_valid && (starve_cnt_r != STARVE_LIM_C)) begin
        starve_cnt_r <= starve_cnt_r + 4'd1;
      end
    end
  end
`endif

  // Transaction sequencing: grant, address phase, response phase.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_s) begin
          state_nxt_s = ST_REQ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (m_addr_ok && m_data_ok) begin
          state_nxt_s = ST_IDLE;
        end else if (m_addr_ok) begin
          state_nxt_s = ST_RESP;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_RESP: begin
        if (m_data_ok) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Capture the winner's request; the port is driven only from these copies.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q_r   <= 64'd0;
      wdata_q_r  <= 64'd0;
      size_q_r   <= 3'd0;
      strobe_q_r <= 8'd0;
      owner_d_r  <= 1'b0;
    end else if (grant_s) begin
      owner_d_r <= win_d_s;
      if (win_d_s) begin
        addr_q_r   <= d_addr;
        wdata_q_r  <= d_wdata;
        size_q_r   <= d_size;
        strobe_q_r <= d_strobe;
      end else begin
        addr_q_r   <= i_addr;
        wdata_q_r  <= 64'd0;
        size_q_r   <= 3'b010;
        strobe_q_r <= 8'h00;
      end
    end
  end

  // Per-side outstanding flags, set on grant and cleared on the owner's response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_pend_r <= 1'b0;
      d_pend_r <= 1'b0;
    end else if (grant_s) begin
      if (win_d_s) begin
        d_pend_r <= 1'b1;
      end else begin
        i_pend_r <= 1'b1;
      end
    end else if (resp_s) begin
      if (owner_d_r) begin
        d_pend_r <= 1'b0;
      end else begin
        i_pend_r <= 1'b0;
      end
    end
  end

  assign i_addr_ok = grant_s & ~win_d_s;
  assign d_addr_ok = grant_s & win_d_s;
  // The pending flag also drops any response still in flight across a reset.
  assign i_data_ok = resp_s & ~owner_d_r & i_pend_r & ~rst;
  assign d_data_ok = resp_s & owner_d_r & d_pend_r & ~rst;
  assign i_data    = i_data_ok ? (addr_q_r[2] ? m_rdata[63:32] : m_rdata[31:0]) : 32'd0;
  assign d_rdata   = d_data_ok ? m_rdata : 64'd0;

  assign m_valid   = (state_r == ST_REQ);
  assign m_addr    = addr_q_r;
  assign m_size    = size_q_r;
  assign m_strobe  = strobe_q_r;
  assign m_wdata   = wdata_q_r;
  assign owner_d   = owner_d_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed stimulus pushes expected grants/responses, a negedge monitor checks them.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid, i_addr_ok, i_data_ok;
  logic [63:0] i_addr;
  logic [31:0] i_data;
  logic        d_valid, d_addr_ok, d_data_ok;
  logic [63:0] d_addr, d_wdata, d_rdata;
  logic [2:0]  d_size;
  logic [7:0]  d_strobe;
  logic        m_valid, m_addr_ok, m_data_ok;
  logic [63:0] m_addr, m_wdata, m_rdata;
  logic [2:0]  m_size;
  logic [7:0]  m_strobe;
  logic        owner_d;

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_addr(i_addr), .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_data(i_data),
    .d_valid(d_valid), .d_addr(d_addr), .d_size(d_size), .d_strobe(d_strobe), .d_wdata(d_wdata),
    .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
    .m_valid(m_valid), .m_addr(m_addr), .m_size(m_size), .m_strobe(m_strobe), .m_wdata(m_wdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
    .owner_d(owner_d)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_d;
    logic [63:0] data;
  } resp_t;

  int    total = 0;
  int    bad   = 0;
  logic  grant_q[$];
  resp_t resp_q[$];
  logic  mon_g;
  resp_t mon_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: event missing or unexpected", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives the port side: waits for m_valid, accepts, responds after lat cycles.
  task automatic serve(input int lat, input logic [63:0] rd);
    int n;
    n = 0;
    while (m_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (m_valid !== 1'b1) begin
      fail("serve_timeout");
    end else begin
      m_rdata   = rd;
      m_addr_ok = 1'b1;
      m_data_ok = (lat == 0);
      tick();
      m_addr_ok = 1'b0;
      m_data_ok = 1'b0;
      if (lat > 0) begin
        repeat (lat - 1) tick();
        m_data_ok = 1'b1;
        tick();
        m_data_ok = 1'b0;
      end
    end
  endtask

  // Monitor: every addr_ok / data_ok pulse must match the head of its queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (i_addr_ok && d_addr_ok) fail("dual_addr_ok");
      if (i_data_ok && d_data_ok) fail("dual_data_ok");
      if (i_addr_ok || d_addr_ok) begin
        if (grant_q.size() == 0) begin
          fail("unexpected_grant");
        end else begin
          mon_g = grant_q.pop_front();
          chk("grant_side", {63'd0, d_addr_ok}, {63'd0, mon_g});
        end
      end
      if (i_data_ok || d_data_ok) begin
        if (resp_q.size() == 0) begin
          fail("unexpected_resp");
        end else begin
          mon_e = resp_q.pop_front();
          chk("resp_side", {63'd0, d_data_ok}, {63'd0, mon_e.is_d});
          chk("resp_data", d_data_ok ? d_rdata : {32'd0, i_data}, mon_e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [4:0]  seq_exp;
    logic [63:0] rd;

    rst = 1'b1;
    i_valid = 1'b1; i_addr = 64'd0;
    d_valid = 1'b1; d_addr = 64'd0; d_size = 3'd0; d_strobe = 8'd0; d_wdata = 64'd0;
    m_addr_ok = 1'b0; m_data_ok = 1'b0; m_rdata = 64'hFFFF_FFFF_FFFF_FFFF;

    // Reset state, with both requests held to show grants are suppressed.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_m_valid", m_valid, 64'd0);
    chk("rst_i_addr_ok", i_addr_ok, 64'd0);
    chk("rst_d_addr_ok", d_addr_ok, 64'd0);
    chk("rst_owner_d", owner_d, 64'd0);
    chk("rst_m_addr", m_addr, 64'd0);
    chk("rst_d_rdata", d_rdata, 64'd0);
    tick();
    rst = 1'b0; i_valid = 1'b0; d_valid = 1'b0; m_rdata = 64'd0;
    tick();

    // Fetch only, upper word selected by address bit 2.
    i_valid = 1'b1; i_addr = 64'h8000_0004;
    grant_q.push_back(1'b0);
    resp_q.push_back('{1'b0, 64'h0000_0000_AAAA_BBBB});
    tick();
    chk("f_m_valid", m_valid, 64'd1);
    chk("f_m_size", m_size, 64'd2);
    chk("f_m_strobe", m_strobe, 64'd0);
    chk("f_m_addr", m_addr, 64'h8000_0004);
    chk("f_m_wdata", m_wdata, 64'd0);
    serve(0, 64'hAAAA_BBBB_CCCC_DDDD);
    i_valid = 1'b0;
    tick();

    // Store with a 3-cycle response latency.
    d_valid = 1'b1; d_addr = 64'h100; d_size = 3'd3; d_strobe = 8'h0F; d_wdata = 64'h1234;
    grant_q.push_back(1'b1);
    resp_q.push_back('{1'b1, 64'h0000_0000_0000_0055});
    tick();
    chk("s_m_strobe", m_strobe, 64'h0F);
    chk("s_m_wdata", m_wdata, 64'h1234);
    chk("s_m_addr", m_addr, 64'h100);
    chk("s_owner_d", owner_d, 64'd1);
    serve(3, 64'h0000_0000_0000_0055);
    d_valid = 1'b0;
    tick();

    // Requester fields change after d_addr_ok; the port keeps the latched copy.
    d_valid = 1'b1; d_addr = 64'h200; d_size = 3'd3; d_strobe = 8'h00; d_wdata = 64'd0;
    grant_q.push_back(1'b1);
    resp_q.push_back('{1'b1, 64'h0123_4567_89AB_CDEF});
    tick();
    d_addr = 64'hDEAD_0000; d_strobe = 8'hFF; d_wdata = 64'hFFFF;
    chk("hold_m_addr_req", m_addr, 64'h200);
    chk("hold_m_strobe", m_strobe, 64'h00);
    m_addr_ok = 1'b1;
    tick();
    m_addr_ok = 1'b0;
    chk("hold_m_valid_resp", m_valid, 64'd0);
    chk("hold_m_addr_resp", m_addr, 64'h200);
    serve_resp_only: begin
      m_rdata = 64'h0123_4567_89AB_CDEF;
      m_data_ok = 1'b1;
      tick();
      m_data_ok = 1'b0;
    end
    d_valid = 1'b0;
    tick();

    // Port handshakes while idle are ignored.
    m_addr_ok = 1'b1; m_data_ok = 1'b1;
    @(negedge clk);
    chk("idle_data_ok", {62'd0, i_data_ok, d_data_ok}, 64'd0);
    tick();
    m_addr_ok = 1'b0; m_data_ok = 1'b0;
    chk("idle_m_valid", m_valid, 64'd0);

    // Reset while waiting for a response; the late response must be dropped.
    i_valid = 1'b1; i_addr = 64'h8000_0008;
    grant_q.push_back(1'b0);
    tick();
    m_addr_ok = 1'b1;
    tick();
    m_addr_ok = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_m_valid", m_valid, 64'd0);
    chk("mid_rst_i_addr_ok", i_addr_ok, 64'd0);
    chk("mid_rst_m_addr", m_addr, 64'd0);
    i_valid = 1'b0;
    tick();
    rst = 1'b0;
    m_rdata = 64'h1111_2222_3333_4444; m_data_ok = 1'b1;
    @(negedge clk);
    chk("late_resp_dropped", {62'd0, i_data_ok, d_data_ok}, 64'd0);
    tick();
    m_data_ok = 1'b0;

    // Fresh fetch after reset, lower word not selected (bit 2 set).
    i_valid = 1'b1; i_addr = 64'h8000_000C;
    grant_q.push_back(1'b0);
    resp_q.push_back('{1'b0, 64'h0000_0000_FEED_FACE});
    tick();
    serve(2, 64'hFEED_FACE_0BAD_F00D);
    i_valid = 1'b0;
    tick();

    // Both requesters held for five grants.
`ifdef RR_ARB_EN
    seq_exp = 5'b10101;
`else
    seq_exp = 5'b01111;
`endif
    i_valid = 1'b1; i_addr = 64'h8000_0010;
    d_valid = 1'b1; d_addr = 64'h300; d_size = 3'd3; d_strobe = 8'h00; d_wdata = 64'd0;
    for (int k = 0; k < 5; k++) begin
      rd = {32'(k + 1), 32'hC0DE_0000 + 32'(k)};
      grant_q.push_back(seq_exp[k]);
      resp_q.push_back('{seq_exp[k], seq_exp[k] ? rd : {32'd0, rd[31:0]}});
    end
    for (int k = 0; k < 5; k++) begin
      rd = {32'(k + 1), 32'hC0DE_0000 + 32'(k)};
      serve(1, rd);
    end
    i_valid = 1'b0; d_valid = 1'b0;
    repeat (3) tick();

    chk("grant_q_drained", grant_q.size(), 64'd0);
    chk("resp_q_drained", resp_q.size(), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
